// File: rtl/ysyx_wbu_flush_seq.sv
// Retire-side flush/fence sequencer: flush, store-buffer drain, I-cache invalidate,
// then a single-cycle fetch redirect to the retiring instruction's npc.
//
// state | meaning
// IDLE  | waiting for a flush / fence event on the retire broadcast
// FLUSH | flush_o held for FLUSH_CYCLES cycles
// DRAIN | store-buffer drain requested, waiting for sb_empty
// INVAL | I-cache invalidate requested, waiting for ack
// REDIR | one-cycle redirect to the latched npc

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_wbu_flush_seq #(
  parameter int XLEN         = `YSYX_XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wbu_valid,
  input  logic            wbu_flush_pipe,
  input  logic            wbu_sys_retire,
  input  logic            wbu_fence_i,
  input  logic            wbu_fence_time,
  input  logic [XLEN-1:0] wbu_npc,
  input  logic            sb_empty,
  input  logic            icache_inv_ack,
  output logic            flush_o,
  output logic            sb_drain_req,
  output logic            icache_inv_req,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            rou_stall,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_DRAIN = 3'd2,
    S_INVAL = 3'd3,
    S_REDIR = 3'd4
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              need_drain_q, need_drain_d;
  logic              need_inv_q, need_inv_d;
  logic              overrun_q, overrun_d;
  logic              trigger;

  assign trigger = wbu_valid &
                   (wbu_flush_pipe | wbu_sys_retire | wbu_fence_i | wbu_fence_time);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    need_drain_d = need_drain_q;
    need_inv_d   = need_inv_q;
    overrun_d    = overrun_q;

    // A second event while a sequence is in flight is dropped, only flagged.
    if (trigger && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          tgt_d        = wbu_npc;
          need_drain_d = wbu_fence_i | wbu_fence_time;
          need_inv_d   = wbu_fence_i;
          cnt_d        = CNT_LOAD;
          state_d      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          if (need_drain_q) begin
            state_d = S_DRAIN;
          end else if (need_inv_q) begin
            state_d = S_INVAL;
          end else begin
            state_d = S_REDIR;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        if (sb_empty) begin
          state_d = need_inv_q ? S_INVAL : S_REDIR;
        end
      end
      S_INVAL: begin
        if (icache_inv_ack) begin
          state_d = S_REDIR;
        end
      end
      S_REDIR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      tgt_q        <= '0;
      need_drain_q <= 1'b0;
      need_inv_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      need_drain_q <= need_drain_d;
      need_inv_q   <= need_inv_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs decode the state register only; no input reaches them combinationally.
  assign flush_o        = (state_q == S_FLUSH);
  assign sb_drain_req   = (state_q == S_DRAIN);
  assign icache_inv_req = (state_q == S_INVAL);
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = tgt_q;
  assign busy           = (state_q != S_IDLE);
  assign rou_stall      = busy;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_ysyx_wbu_flush_seq.sv
// Self-checking bench for ysyx_wbu_flush_seq: vector table, directed multi-cycle
// sequences, and randomized traffic against a phase-queue reference model.

module tb_ysyx_wbu_flush_seq;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            wbu_valid, wbu_flush_pipe, wbu_sys_retire, wbu_fence_i, wbu_fence_time;
  logic [XLEN-1:0] wbu_npc;
  logic            sb_empty, icache_inv_ack;
  logic            flush_o, sb_drain_req, icache_inv_req, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            rou_stall, busy, overrun;

  always #5 clock = ~clock;

  ysyx_wbu_flush_seq #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clock          (clock),
    .reset          (reset),
    .wbu_valid      (wbu_valid),
    .wbu_flush_pipe (wbu_flush_pipe),
    .wbu_sys_retire (wbu_sys_retire),
    .wbu_fence_i    (wbu_fence_i),
    .wbu_fence_time (wbu_fence_time),
    .wbu_npc        (wbu_npc),
    .sb_empty       (sb_empty),
    .icache_inv_ack (icache_inv_ack),
    .flush_o        (flush_o),
    .sb_drain_req   (sb_drain_req),
    .icache_inv_req (icache_inv_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rou_stall      (rou_stall),
    .busy           (busy),
    .overrun        (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ev = {valid, flush_pipe, sys_retire, fence_i, fence_time}
  task automatic set_in(input logic [4:0] ev, input logic [31:0] npc);
    {wbu_valid, wbu_flush_pipe, wbu_sys_retire, wbu_fence_i, wbu_fence_time} = ev;
    wbu_npc = npc;
  endtask

  typedef struct {
    logic [4:0]  ev;
    logic [31:0] npc;
    logic        e_flush;
    logic        e_redir;
    logic        e_busy;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ev, input logic [31:0] npc,
                              input logic [2:0] e, input logic [31:0] pc);
    vec_t v;
    v.ev      = ev;
    v.npc     = npc;
    v.e_flush = e[2];
    v.e_redir = e[1];
    v.e_busy  = e[0];
    v.e_pc    = pc;
    return v;
  endfunction

  vec_t tbl[21];

  // Walks one sequence; the bench plays store buffer and I-cache.
  task automatic run_seq(input string nm, input logic [4:0] ev, input logic [31:0] npc,
                         input int drain_wait, input int ack_delay, input logic ovr,
                         output int nf, output int nd, output int ni, output int nr,
                         output logic [31:0] rpc, output int order_err, output int stall_err);
    int prev;
    int ph;
    int nhot;
    nf = 0; nd = 0; ni = 0; nr = 0; rpc = '0; order_err = 0; stall_err = 0; prev = 0;
    sb_empty = (drain_wait == 0);
    icache_inv_ack = 1'b0;
    set_in(ev, npc);
    tick();
    set_in(5'b0, 32'h0);
    for (int k = 0; k < 60 && busy === 1'b1; k++) begin
      nhot = int'(flush_o) + int'(sb_drain_req) + int'(icache_inv_req) + int'(redirect_valid);
      ph = flush_o ? 1 : sb_drain_req ? 2 : icache_inv_req ? 3 : redirect_valid ? 4 : 0;
      if (nhot != 1 || ph < prev) order_err++;
      if (rou_stall !== 1'b1) stall_err++;
      prev = ph;
      icache_inv_ack = 1'b0;
      set_in(5'b0, 32'h0);
      case (ph)
        1: nf++;
        2: begin
          nd++;
          sb_empty = (drain_wait == 0) || (nd > drain_wait);
          if (ovr && nd == 1) set_in(5'b11000, 32'h0000_1234);
        end
        3: begin
          ni++;
          icache_inv_ack = (ni > ack_delay);
        end
        4: begin
          nr++;
          rpc = redirect_pc;
        end
        default: ;
      endcase
      tick();
    end
    set_in(5'b0, 32'h0);
    icache_inv_ack = 1'b0;
    chk1({nm, "_done"}, busy, 1'b0);
  endtask

  // Reference model: queue of remaining phases (1 flush, 2 drain, 3 inval, 4 redir).
  int          m_q[$];
  logic [31:0] m_tgt;
  logic        m_ovr;

  task automatic model_step(input logic rst, input logic [4:0] ev, input logic [31:0] npc,
                            input logic sbe, input logic ack);
    logic trig;
    logic was_busy;
    if (rst) begin
      m_q.delete();
      m_tgt = '0;
      m_ovr = 1'b0;
    end else begin
      trig     = ev[4] && (ev[3:0] != 4'b0);
      was_busy = (m_q.size() != 0);
      if (was_busy) begin
        if (m_q[0] == 1 || m_q[0] == 4 || (m_q[0] == 2 && sbe) || (m_q[0] == 3 && ack))
          void'(m_q.pop_front());
      end
      if (trig) begin
        if (was_busy) begin
          m_ovr = 1'b1;
        end else begin
          m_tgt = npc;
          for (int i = 0; i < FC; i++) m_q.push_back(1);
          if (ev[1] || ev[0]) m_q.push_back(2);
          if (ev[1]) m_q.push_back(3);
          m_q.push_back(4);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nf, nd, ni, nr, oe, se;
    logic [31:0] rpc;
    logic        r_rst, r_sbe, r_ack;
    logic [4:0]  r_ev;
    logic [31:0] r_npc;
    logic [31:0] act_v, exp_v;
    int          ph;
    bit          seen;

    reset = 1'b1;
    set_in(5'b0, 32'h0);
    sb_empty = 1'b0;
    icache_inv_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk32("reset_outs",
          {24'd0, flush_o, sb_drain_req, icache_inv_req, redirect_valid, busy, rou_stall, overrun, 1'b0},
          32'd0);
    chk32("reset_tgt", redirect_pc, 32'd0);

    tbl[0]  = mk(5'b11000, 32'h8000_0010, 3'b000, 32'h0);
    tbl[1]  = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[2]  = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[3]  = mk(5'b00000, 32'h0,         3'b011, 32'h8000_0010);
    tbl[4]  = mk(5'b00000, 32'h0,         3'b000, 32'h0);
    tbl[5]  = mk(5'b10100, 32'h0000_0100, 3'b000, 32'h0);
    tbl[6]  = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[7]  = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[8]  = mk(5'b00000, 32'h0,         3'b011, 32'h0000_0100);
    tbl[9]  = mk(5'b00000, 32'h0,         3'b000, 32'h0);
    tbl[10] = mk(5'b01111, 32'hdead_beef, 3'b000, 32'h0);
    tbl[11] = mk(5'b00000, 32'h0,         3'b000, 32'h0);
    tbl[12] = mk(5'b11000, 32'h0000_00a0, 3'b000, 32'h0);
    tbl[13] = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[14] = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[15] = mk(5'b00000, 32'h0,         3'b011, 32'h0000_00a0);
    tbl[16] = mk(5'b10100, 32'h0000_00b0, 3'b000, 32'h0);
    tbl[17] = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[18] = mk(5'b00000, 32'h0,         3'b101, 32'h0);
    tbl[19] = mk(5'b00000, 32'h0,         3'b011, 32'h0000_00b0);
    tbl[20] = mk(5'b00000, 32'h0,         3'b000, 32'h0);

    for (int i = 0; i < 21; i++) begin
      chk1($sformatf("tbl%0d_flush", i), flush_o, tbl[i].e_flush);
      chk1($sformatf("tbl%0d_redir", i), redirect_valid, tbl[i].e_redir);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("tbl%0d_stall", i), rou_stall, tbl[i].e_busy);
      chk1($sformatf("tbl%0d_drain_inv", i), sb_drain_req | icache_inv_req, 1'b0);
      chk1($sformatf("tbl%0d_overrun", i), overrun, 1'b0);
      if (tbl[i].e_redir) chk32($sformatf("tbl%0d_pc", i), redirect_pc, tbl[i].e_pc);
      set_in(tbl[i].ev, tbl[i].npc);
      tick();
    end
    set_in(5'b0, 32'h0);

    // fence.i: sb_empty low 3 drain cycles, ack 2 cycles after request rises
    run_seq("fencei", 5'b10010, 32'h0000_2000, 3, 2, 1'b0, nf, nd, ni, nr, rpc, oe, se);
    chk32("fencei_nflush", nf, 2);
    chk32("fencei_ndrain", nd, 4);
    chk32("fencei_ninval", ni, 3);
    chk32("fencei_nredir", nr, 1);
    chk32("fencei_pc", rpc, 32'h0000_2000);
    chk32("fencei_order", oe, 0);
    chk32("fencei_stall", se, 0);

    // time fence with store buffer already empty
    run_seq("ftime", 5'b10001, 32'h0000_3000, 0, 0, 1'b0, nf, nd, ni, nr, rpc, oe, se);
    chk32("ftime_nflush", nf, 2);
    chk32("ftime_ndrain", nd, 1);
    chk32("ftime_ninval", ni, 0);
    chk32("ftime_nredir", nr, 1);
    chk32("ftime_pc", rpc, 32'h0000_3000);
    chk32("ftime_order", oe, 0);

    // idle retire traffic without event bits
    for (int i = 0; i < 10; i++) begin
      set_in(5'b10000, $urandom);
      tick();
      chk1($sformatf("noev%0d_busy", i), busy, 1'b0);
      chk1($sformatf("noev%0d_flush", i), flush_o, 1'b0);
      chk1($sformatf("noev%0d_redir", i), redirect_valid, 1'b0);
    end
    set_in(5'b0, 32'h0);

    // second trigger during DRAIN
    chk1("ovr_before", overrun, 1'b0);
    run_seq("ovr", 5'b10001, 32'h0000_5000, 2, 0, 1'b1, nf, nd, ni, nr, rpc, oe, se);
    chk32("ovr_ndrain", nd, 3);
    chk32("ovr_nredir", nr, 1);
    chk32("ovr_pc", rpc, 32'h0000_5000);
    chk1("ovr_flag", overrun, 1'b1);
    tick();
    tick();
    tick();
    chk1("ovr_sticky", overrun, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("ovr_cleared", overrun, 1'b0);

    // reset while in INVAL
    sb_empty = 1'b1;
    icache_inv_ack = 1'b0;
    set_in(5'b10010, 32'h0000_7000);
    tick();
    set_in(5'b0, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (icache_inv_req === 1'b1) seen = 1'b1;
      else tick();
    end
    chk1("rstinv_reached", seen, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk32("rstinv_outs",
          {24'd0, flush_o, sb_drain_req, icache_inv_req, redirect_valid, busy, rou_stall, overrun, 1'b0},
          32'd0);
    chk32("rstinv_tgt", redirect_pc, 32'd0);
    icache_inv_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1($sformatf("rstinv_ack%0d_redir", i), redirect_valid, 1'b0);
      chk1($sformatf("rstinv_ack%0d_busy", i), busy, 1'b0);
    end
    icache_inv_ack = 1'b0;
    sb_empty = 1'b0;

    // randomized traffic against the phase-queue model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_step(1'b1, 5'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      ph = (m_q.size() != 0) ? m_q[0] : 0;
      act_v = {25'd0, flush_o, sb_drain_req, icache_inv_req, redirect_valid, busy, rou_stall, overrun};
      exp_v = {25'd0, ph == 1, ph == 2, ph == 3, ph == 4, ph != 0, ph != 0, m_ovr};
      chk32($sformatf("rand%0d_outs", c), act_v, exp_v);
      if (ph == 4) chk32($sformatf("rand%0d_pc", c), redirect_pc, m_tgt);

      r_rst = ($urandom_range(0, 299) == 0);
      r_ev  = {$urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
      r_npc = $urandom;
      r_sbe = ($urandom_range(0, 3) == 0);
      r_ack = ($urandom_range(0, 3) == 0);
      reset = r_rst;
      set_in(r_ev, r_npc);
      sb_empty = r_sbe;
      icache_inv_ack = r_ack;
      tick();
      model_step(r_rst, r_ev, r_npc, r_sbe, r_ack);
    end
    reset = 1'b0;
    set_in(5'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_wbu_flush_seq.md
# ysyx_wbu_flush_seq

Retire-side flush and fence sequencer placed directly after the writeback stage. It watches the per-cycle retire broadcast for pipeline-flush, `fence.i` and time-fence events. For each event it steps through a fixed sequence:

- a timed pipeline flush,
- a store-buffer drain,
- an I-cache invalidate handshake,
- a single-cycle fetch redirect to the retiring instruction's `npc`.

While the sequence runs it holds the reorder unit stalled.

## Interface
Parameters:
- `XLEN`, default `` `YSYX_XLEN ``: PC width.
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` stays high per event. Legal range 1..15.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `wbu_valid`  in  1  retire broadcast valid this cycle.
- `wbu_flush_pipe`  in  1  retiring instruction requires a pipeline flush.
- `wbu_sys_retire`  in  1  system/CSR instruction retired; treated as a flush.
- `wbu_fence_i`  in  1  `fence.i` retired.
- `wbu_fence_time`  in  1  time-fence retired.
- `wbu_npc`  in  XLEN  next PC of the retiring instruction.
- `sb_empty`  in  1  store buffer empty.
- `icache_inv_ack`  in  1  I-cache invalidate complete; 1-cycle pulse or level.
- `flush_o`  out  1  kill all speculative pipeline state.
- `sb_drain_req`  out  1  request store-buffer drain.
- `icache_inv_req`  out  1  request full I-cache invalidate.
- `redirect_valid`  out  1  fetch redirect strobe.
- `redirect_pc`  out  XLEN  redirect target.
- `rou_stall`  out  1  block further retirement.
- `busy`  out  1  sequencer not idle.
- `overrun`  out  1  sticky error flag.

## Operation
- States: IDLE, FLUSH, DRAIN, INVAL, REDIR.
- Trigger: `wbu_valid` & (`flush_pipe` | `sys_retire` | `fence_i` | `fence_time`).
- IDLE, on trigger, in one cycle:
  - latch `wbu_npc` into `tgt`;
  - latch `need_drain` = `fence_i` | `fence_time`;
  - latch `need_inv` = `fence_i`;
  - load `cnt` = `FLUSH_CYCLES`-1;
  - go to FLUSH.
- IDLE, `wbu_valid` with no event bits set: no action.
- FLUSH:
  - `flush_o`=1;
  - `cnt` decrements each cycle;
  - at `cnt`==0 go to DRAIN if `need_drain`, else INVAL if `need_inv`, else REDIR.
- DRAIN:
  - `sb_drain_req`=1;
  - when `sb_empty` is sampled 1, go to INVAL if `need_inv`, else REDIR.
  - `sb_empty` already high on entry still costs one DRAIN cycle.
- INVAL:
  - `icache_inv_req`=1;
  - when `icache_inv_ack` is sampled 1, go to REDIR.
  - The request drops on the next cycle, together with the state change.
- REDIR: `redirect_valid`=1 and `redirect_pc`=`tgt` for exactly one cycle, then IDLE.
- `busy` = (state != IDLE).
- `rou_stall` = `busy`, combinational from the state register.
- Overrun: a trigger arriving while `busy`=1 is ignored (no relatch of `tgt` or the need bits) and sets `overrun`=1. `overrun` clears only on reset.
- `redirect_pc` outside REDIR drives `tgt`; it is don't-care when `redirect_valid`=0.
- `icache_inv_ack` or `sb_empty` seen outside INVAL or DRAIN: ignored.

## Timing
- Reset values:
  - state IDLE;
  - `flush_o`, `sb_drain_req`, `icache_inv_req`, `redirect_valid`, `busy`, `rou_stall`, `overrun` all 0;
  - `tgt` = 0, `cnt` = 0.
- Reset asserted mid-sequence: abort immediately, no redirect issued, all outputs 0 on the next edge.
- All state-driven outputs (`flush_o`, `sb_drain_req`, `icache_inv_req`, `redirect_valid`) are decoded from registered state only, with no input-to-output combinational path.
- Latency, trigger sampled at edge T:
  - `flush_o` high during cycles T+1 .. T+`FLUSH_CYCLES`.
  - Plain flush: `redirect_valid` at T+`FLUSH_CYCLES`+1; back in IDLE at T+`FLUSH_CYCLES`+2.
  - Drain: at least 1 cycle, plus the wait for `sb_empty`.
  - Invalidate: at least 1 cycle, plus the wait for ack.
- Back-to-back triggers: a trigger on the cycle after REDIR (state IDLE again) is accepted normally. A trigger during REDIR is an overrun.
- No timeout: DRAIN and INVAL wait indefinitely.

## Test plan
- Plain flush, `FLUSH_CYCLES`=2: `flush_pipe`=1, `npc`=0x8000_0010 at T -> `flush_o` at T+1 and T+2; `redirect_valid`, `redirect_pc`=0x8000_0010 at T+3; `busy` low at T+4.
- `fence.i` with `sb_empty`=0 for 3 cycles and ack 2 cycles after `icache_inv_req` rises -> sequence FLUSH(2), DRAIN(4), INVAL(3), REDIR(1); `rou_stall` high throughout.
- Time-fence with `sb_empty` already 1 -> DRAIN lasts 1 cycle; `icache_inv_req` never asserts; redirect to the latched npc.
- Second trigger (`npc`=0x1234) during DRAIN -> `overrun`=1 sticky; the redirect still uses the first npc.
- Reset pulse while in INVAL -> next cycle all outputs 0 and state IDLE; a later ack has no effect; no `redirect_valid`.
- `wbu_valid`=1 with no event bits for 10 cycles -> `busy`, `flush_o` and `redirect_valid` stay 0.
